// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl: synchronises 8 interrupt request lines, holds them as pending, masks
// them toward an external 8:3 priority encoder and offers the encoder's result to a consumer
// through a valid/ack handshake.
//
// Build option: define IRQ_EDGE_EN for edge mode. In edge mode a rising request sets a
// pending bit that the consumer's ack clears. With the macro undefined (default), the
// design runs in level mode: pending is the synchronised line itself, and the source ends
// service by dropping its line.
module irq_pending_ctrl #(
   parameter int unsigned NUM_IRQ  = 8,
   parameter int unsigned ID_W     = 3,
   parameter int unsigned SYNC_STG = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [NUM_IRQ-1:0] irq_mask,
   output logic [NUM_IRQ-1:0] pend_vec,
   input  logic [ID_W-1:0]    enc_id,
   output logic               irq_valid,
   output logic [ID_W-1:0]    irq_id,
   input  logic               irq_ack,
   output logic [NUM_IRQ-1:0] pend_raw
);

   typedef enum logic [1:0] {StIdle, StLatch, StValid} state_t;

   state_t                           state_q;
   logic [SYNC_STG-1:0][NUM_IRQ-1:0] sync_q;
   logic [NUM_IRQ-1:0]               s_q;
   logic [NUM_IRQ-1:0]               pend;
   logic                             ack_fire;

   // Synchroniser chain, one SYNC_STG-deep chain per request line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= irq_in;
         for (int k = 1; k < int'(SYNC_STG); k++) begin
            sync_q[k] <= sync_q[k-1];
         end
      end
   end

   assign s_q      = sync_q[SYNC_STG-1];
   assign ack_fire = (state_q == StValid) && irq_ack;

`ifdef IRQ_EDGE_EN
   logic [NUM_IRQ-1:0] s_d_q;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] clr;
   logic [NUM_IRQ-1:0] pend_q;

   // Edge-delay copy of the synchronised lines; cleared at reset so a line already high
   // at reset release produces one rise
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_d_q <= '0;
      end else begin
         s_d_q <= s_q;
      end
   end

   // Rise detect and the one-hot clear of the serviced bit
   always_comb begin
      rise = s_q & ~s_d_q;
      clr  = '0;
      if (ack_fire) begin
         clr[irq_id] = 1'b1;
      end
   end

   // Pending register: a same-edge rise wins over the ack clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= (pend_q & ~clr) | rise;
      end
   end

   assign pend = pend_q;
`else
   // Level mode: pending is the synchronised line, so the ack has no clearing effect
   assign pend = s_q;
`endif

   assign pend_raw = pend;
   assign pend_vec = pend & irq_mask;

   // Offer FSM with registered valid/id; LATCH gives the encoder one cycle to settle
   // and the offer is never retracted once made
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         irq_valid <= 1'b0;
         irq_id    <= '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (|pend_vec) begin
                  state_q <= StLatch;
               end
            end
            StLatch: begin
               if (|pend_vec) begin
                  irq_id    <= enc_id;
                  irq_valid <= 1'b1;
                  state_q   <= StValid;
               end else begin
                  state_q <= StIdle;
               end
            end
            StValid: begin
               if (ack_fire) begin
                  irq_valid <= 1'b0;
                  state_q   <= StIdle;
               end
            end
            default: begin
               irq_valid <= 1'b0;
               state_q   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// tb_irq_pending_ctrl: directed bench for irq_pending_ctrl with a behavioural 8:3
// priority encoder (highest index wins) on the enc_id return path. Expectations for
// edge mode (IRQ_EDGE_EN defined) and level mode (default) are both covered.
module tb_irq_pending_ctrl;

`ifdef IRQ_EDGE_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 4;
`endif

   logic       clk;
   logic       rst_n;
   logic [7:0] irq_in;
   logic [7:0] irq_mask;
   logic [7:0] pend_vec;
   logic [2:0] enc_id;
   logic       irq_valid;
   logic [2:0] irq_id;
   logic       irq_ack;
   logic [7:0] pend_raw;

   int checks = 0;
   int errors = 0;
   logic seen;

   irq_pending_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .irq_in    (irq_in),
      .irq_mask  (irq_mask),
      .pend_vec  (pend_vec),
      .enc_id    (enc_id),
      .irq_valid (irq_valid),
      .irq_id    (irq_id),
      .irq_ack   (irq_ack),
      .pend_raw  (pend_raw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Encoder model: highest set bit of pend_vec
   always_comb begin
      enc_id = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (pend_vec[i]) enc_id = 3'(i);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic wait_offer(input string tag, input logic [2:0] exp_id);
      int n;
      n = 0;
      while (!irq_valid && n < 12) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 8'(irq_valid), 8'h01);
      chk({tag, "_id"}, 8'(irq_id), 8'(exp_id));
   endtask

   task automatic drop_and_ack(input string tag);
      irq_in = 8'h00;
      repeat (3) tick();
      do_ack();
      chk({tag, "_valid"}, 8'(irq_valid), 8'h00);
      chk({tag, "_pend"}, pend_raw, 8'h00);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout irq_valid=%b", irq_valid);
      $fatal(1, "bench timeout");
   end

   initial begin
      rst_n    = 1'b0;
      irq_in   = 8'h00;
      irq_mask = 8'hFF;
      irq_ack  = 1'b0;

      // Reset and idle
      #2;
      chk("rst_valid", 8'(irq_valid), 8'h00);
      chk("rst_id", 8'(irq_id), 8'h00);
      chk("rst_pvec", pend_vec, 8'h00);
      chk("rst_praw", pend_raw, 8'h00);
      tick();
      tick();
      rst_n = 1'b1;
      seen  = 1'b0;
      repeat (20) begin
         tick();
         seen |= irq_valid;
      end
      chk("idle_valid", 8'(seen), 8'h00);

      // Single request, exact latency
      irq_in = 8'h20;
      for (int i = 1; i < LAT; i++) tick();
      chk("single_early", 8'(irq_valid), 8'h00);
      tick();
      chk("single_valid", 8'(irq_valid), 8'h01);
      chk("single_id", 8'(irq_id), 8'h05);
      chk("single_praw", pend_raw, 8'h20);
      chk("single_pvec", pend_vec, 8'h20);
`ifdef IRQ_EDGE_EN
      do_ack();
      chk("single_ack_valid", 8'(irq_valid), 8'h00);
      chk("single_ack_praw", pend_raw, 8'h00);
      seen = 1'b0;
      repeat (6) begin
         tick();
         seen |= irq_valid;
      end
      chk("single_no_reoffer", 8'(seen), 8'h00);
      irq_in = 8'h00;
      repeat (3) tick();
`else
      drop_and_ack("single_drop");
      seen = 1'b0;
      repeat (4) begin
         tick();
         seen |= irq_valid;
      end
      chk("single_quiet", 8'(seen), 8'h00);
`endif

      // Priority order and back-to-back gap
      irq_in = 8'h81;
      wait_offer("prio_first", 3'd7);
      irq_in = 8'h01;
      repeat (3) tick();
      chk("prio_held_valid", 8'(irq_valid), 8'h01);
      chk("prio_held_id", 8'(irq_id), 8'h07);
`ifdef IRQ_EDGE_EN
      chk("prio_held_praw", pend_raw, 8'h81);
`else
      chk("prio_held_praw", pend_raw, 8'h01);
`endif
      do_ack();
      chk("prio_gap1", 8'(irq_valid), 8'h00);
      chk("prio_gap_praw", pend_raw, 8'h01);
      tick();
      chk("prio_gap2", 8'(irq_valid), 8'h00);
      tick();
      chk("prio_second_valid", 8'(irq_valid), 8'h01);
      chk("prio_second_id", 8'(irq_id), 8'h00);
      drop_and_ack("prio_end");

      // Masked request stays pending and is serviced once unmasked
      irq_mask = 8'hFE;
      irq_in   = 8'h01;
      seen     = 1'b0;
      repeat (10) begin
         tick();
         seen |= irq_valid;
      end
      chk("mask_no_valid", 8'(seen), 8'h00);
      chk("mask_praw", pend_raw, 8'h01);
      chk("mask_pvec", pend_vec, 8'h00);
      irq_mask = 8'hFF;
      tick();
      chk("unmask_gap", 8'(irq_valid), 8'h00);
      tick();
      chk("unmask_valid", 8'(irq_valid), 8'h01);
      chk("unmask_id", 8'(irq_id), 8'h00);
      drop_and_ack("mask_end");

      // Mask during LATCH aborts the offer
      irq_in = 8'h02;
      for (int i = 1; i < LAT; i++) tick();
      irq_mask = 8'h00;
      seen     = 1'b0;
      repeat (5) begin
         tick();
         seen |= irq_valid;
      end
      chk("latch_abort", 8'(seen), 8'h00);
      irq_mask = 8'hFF;
      tick();
      tick();
      chk("latch_retry_valid", 8'(irq_valid), 8'h01);
      chk("latch_retry_id", 8'(irq_id), 8'h01);

      // Offer is not retracted when its line is masked and dropped
      irq_in   = 8'h00;
      irq_mask = 8'h00;
      repeat (3) tick();
      chk("keep_valid", 8'(irq_valid), 8'h01);
      chk("keep_id", 8'(irq_id), 8'h01);
      do_ack();
      chk("keep_ack", 8'(irq_valid), 8'h00);
      irq_mask = 8'hFF;
      repeat (3) tick();
      chk("keep_after_valid", 8'(irq_valid), 8'h00);
      chk("keep_after_praw", pend_raw, 8'h00);

`ifdef IRQ_EDGE_EN
      // Set/clear collision on bit 3: set wins
      irq_in = 8'h08;
      wait_offer("coll_first", 3'd3);
      irq_in = 8'h00;
      repeat (3) tick();
      irq_in = 8'h08;
      tick();
      tick();
      do_ack();
      chk("coll_ack_valid", 8'(irq_valid), 8'h00);
      chk("coll_praw", pend_raw, 8'h08);
      tick();
      chk("coll_gap", 8'(irq_valid), 8'h00);
      tick();
      chk("coll_second_valid", 8'(irq_valid), 8'h01);
      chk("coll_second_id", 8'(irq_id), 8'h03);
      drop_and_ack("coll_end");
`else
      // Level mode: line held through the ack is re-offered after the gap
      irq_in = 8'h04;
      wait_offer("lvl_first", 3'd2);
      do_ack();
      chk("lvl_ack_valid", 8'(irq_valid), 8'h00);
      chk("lvl_praw", pend_raw, 8'h04);
      tick();
      chk("lvl_gap", 8'(irq_valid), 8'h00);
      tick();
      chk("lvl_reoffer_valid", 8'(irq_valid), 8'h01);
      chk("lvl_reoffer_id", 8'(irq_id), 8'h02);
      drop_and_ack("lvl_end");
`endif

      // Reset mid-offer, then re-trigger from the reset-release rise
      irq_in = 8'h40;
      wait_offer("rmid_first", 3'd6);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rmid_valid", 8'(irq_valid), 8'h00);
      chk("rmid_id", 8'(irq_id), 8'h00);
      chk("rmid_praw", pend_raw, 8'h00);
      chk("rmid_pvec", pend_vec, 8'h00);
      tick();
      rst_n = 1'b1;
      for (int i = 1; i < LAT; i++) tick();
      chk("rel_early", 8'(irq_valid), 8'h00);
      tick();
      chk("rel_valid", 8'(irq_valid), 8'h01);
      chk("rel_id", 8'(irq_id), 8'h06);
      drop_and_ack("rel_end");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
